// File: rtl/dmem_bridge.sv
// dmem_bridge: connects the single-cycle datapath's load/store port to a
// variable-latency data-memory bus.
//
// An aligned access is launched on the bus from IDLE. The bridge then waits in
// BUSY for bus_ack_i, or until TIMEOUT cycles have passed. It finishes with one
// DONE cycle in which the core commits the instruction. A misaligned access
// skips the bus and goes straight to DONE.
//
// Ports:
//   clk_i          clock, rising edge
//   reset_i        asynchronous active-low reset
//   mem_read_i     load strobe from controller
//   mem_write_i    store strobe from controller (wins when both are high)
//   addr_i32       byte address from the ALU
//   wdata_i32      store data from the register file
//   rdata_o32      registered load data to the datapath
//   stall_o        hold PC and suppress register write while high
//   bus_req_o      bus request, high only in BUSY
//   bus_we_o       bus write enable (registered, held outside BUSY)
//   bus_addr_o32   word-aligned bus address (registered)
//   bus_wdata_o32  bus write data (registered)
//   bus_ack_i      bus completion
//   bus_rdata_i32  bus read data, valid with bus_ack_i
//   err_o          sticky error flag
//   err_code_o2    sticky first error: 00 none, 01 misaligned, 10 timeout

module dmem_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i32,
    input  logic [31:0] wdata_i32,
    output logic [31:0] rdata_o32,
    output logic        stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o32,
    output logic [31:0] bus_wdata_o32,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i32,
    output logic        err_o,
    output logic [1:0]  err_code_o2
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    // Last counter value before the timeout fires; the counter never goes past it.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    localparam logic [1:0] ErrNone     = 2'b00;
    localparam logic [1:0] ErrMisalign = 2'b01;
    localparam logic [1:0] ErrTimeout  = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [31:0]       rdata_q;
    logic [31:0]       bus_addr_q;
    logic [31:0]       bus_wdata_q;
    logic              bus_we_q;
    logic [1:0]        err_code_q;

    logic access;
    logic aligned;

    assign access  = mem_read_i | mem_write_i;
    assign aligned = (addr_i32[1:0] == 2'b00);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rdata_q     <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            err_code_q  <= ErrNone;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (access) begin
                        if (aligned) begin
                            bus_addr_q  <= addr_i32;
                            bus_wdata_q <= wdata_i32;
                            // A store wins when both strobes are set.
                            bus_we_q    <= mem_write_i;
                            cnt_q       <= '0;
                            state_q     <= StBusy;
                        end else begin
                            rdata_q <= '0;
                            if (err_code_q == ErrNone) begin
                                err_code_q <= ErrMisalign;
                            end
                            state_q <= StDone;
                        end
                    end
                end
                StBusy: begin
                    // The ack is checked first, so it beats a timeout on the same edge.
                    if (bus_ack_i) begin
                        if (!bus_we_q) begin
                            rdata_q <= bus_rdata_i32;
                        end
                        state_q <= StDone;
                    end else if (cnt_q == CntLast) begin
                        rdata_q <= '0;
                        if (err_code_q == ErrNone) begin
                            err_code_q <= ErrTimeout;
                        end
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Stall in IDLE follows the strobes directly so the PC is held on the launch cycle.
    always_comb begin
        stall_o = 1'b0;
        unique case (state_q)
            StIdle:  stall_o = access;
            StBusy:  stall_o = 1'b1;
            StDone:  stall_o = 1'b0;
            default: stall_o = 1'b0;
        endcase
    end

    assign bus_req_o     = (state_q == StBusy);
    assign bus_we_o      = bus_we_q;
    assign bus_addr_o32  = bus_addr_q;
    assign bus_wdata_o32 = bus_wdata_q;
    assign rdata_o32     = rdata_q;
    assign err_code_o2   = err_code_q;
    assign err_o         = (err_code_q != ErrNone);

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge with TIMEOUT=4. Each table row gives the
// inputs for one clock cycle and the outputs expected during that cycle. Hand
// sequences then cover reset mid-transaction and error stickiness.

module tb_dmem_bridge;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic [31:0] addr_i32;
    logic [31:0] wdata_i32;
    logic [31:0] rdata_o32;
    logic        stall_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o32;
    logic [31:0] bus_wdata_o32;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i32;
    logic        err_o;
    logic [1:0]  err_code_o2;

    int n_checks = 0;
    int n_errors = 0;

    dmem_bridge #(
        .TIMEOUT(4)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .addr_i32      (addr_i32),
        .wdata_i32     (wdata_i32),
        .rdata_o32     (rdata_o32),
        .stall_o       (stall_o),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o32  (bus_addr_o32),
        .bus_wdata_o32 (bus_wdata_o32),
        .bus_ack_i     (bus_ack_i),
        .bus_rdata_i32 (bus_rdata_i32),
        .err_o         (err_o),
        .err_code_o2   (err_code_o2)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] ardata;
        logic        stall;
        logic        req;
        logic        we;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [31:0] rdata;
        logic [1:0]  ec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic ack, input logic [31:0] ardata,
                       input logic stall, input logic req, input logic we,
                       input logic [31:0] baddr, input logic [31:0] bwdata,
                       input logic [31:0] rdata, input logic [1:0] ec);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.ack = ack; v.ardata = ardata;
        v.stall = stall; v.req = req; v.we = we; v.baddr = baddr; v.bwdata = bwdata;
        v.rdata = rdata; v.ec = ec;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic ack, input logic [31:0] ardata);
        mem_read_i    = rd;
        mem_write_i   = wr;
        addr_i32      = addr;
        wdata_i32     = wdata;
        bus_ack_i     = ack;
        bus_rdata_i32 = ardata;
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Run the current access until stall drops (DONE), counting stall and request
    // cycles. Strobes are released in DONE so the bridge returns to a quiet IDLE.
    task automatic run_access(output int n_stall, output int n_req, output bit done);
        n_stall = 0;
        n_req   = 0;
        done    = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk_i);
            if (bus_req_o) n_req++;
            if (stall_o) begin
                n_stall++;
            end else begin
                done = 1;
                drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
            end
            next_cycle();
        end
    endtask

    initial begin
        int  n_stall;
        int  n_req;
        bit  done;

        // Cycle table. Bus registers hold their last values outside BUSY.
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Load 0x10, ack on third BUSY cycle.
        add(1, 0, 'h10, 0, 0, 0,           1, 0, 0, 'h0,  0, 0, 0);
        add(1, 0, 'h10, 0, 0, 0,           1, 1, 0, 'h10, 0, 0, 0);
        add(1, 0, 'h10, 0, 0, 0,           1, 1, 0, 'h10, 0, 0, 0);
        add(1, 0, 'h10, 0, 1, 'hCAFEF00D,  1, 1, 0, 'h10, 0, 0, 0);
        add(1, 0, 'h10, 0, 0, 0,           0, 0, 0, 'h10, 0, 'hCAFEF00D, 0);
        // Store to 0x20, immediate ack; read data must not change.
        add(0, 1, 'h20, 'h12345678, 0, 0,          1, 0, 0, 'h10, 0, 'hCAFEF00D, 0);
        add(0, 1, 'h20, 'h12345678, 1, 'hDEADBEEF, 1, 1, 1, 'h20, 'h12345678, 'hCAFEF00D, 0);
        add(0, 1, 'h20, 'h12345678, 0, 0,          0, 0, 1, 'h20, 'h12345678, 'hCAFEF00D, 0);
        // Both strobes: treated as a store.
        add(1, 1, 'h24, 'hA5A5A5A5, 0, 0,          1, 0, 1, 'h20, 'h12345678, 'hCAFEF00D, 0);
        add(1, 1, 'h24, 'hA5A5A5A5, 1, 'h11111111, 1, 1, 1, 'h24, 'hA5A5A5A5, 'hCAFEF00D, 0);
        add(1, 1, 'h24, 'hA5A5A5A5, 0, 0,          0, 0, 1, 'h24, 'hA5A5A5A5, 'hCAFEF00D, 0);
        // Load 0x40, ack on 4th BUSY cycle (same edge as timeout: ack wins).
        add(1, 0, 'h40, 0, 0, 0,           1, 0, 1, 'h24, 'hA5A5A5A5, 'hCAFEF00D, 0);
        for (int i = 0; i < 3; i++) add(1, 0, 'h40, 0, 0, 0, 1, 1, 0, 'h40, 0, 'hCAFEF00D, 0);
        add(1, 0, 'h40, 0, 1, 'h55AA55AA,  1, 1, 0, 'h40, 0, 'hCAFEF00D, 0);
        add(1, 0, 'h40, 0, 0, 0,           0, 0, 0, 'h40, 0, 'h55AA55AA, 0);
        // Load 0x50, no ack: timeout after 4 BUSY cycles.
        add(1, 0, 'h50, 'h99, 0, 0,        1, 0, 0, 'h40, 0, 'h55AA55AA, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 'h50, 'h99, 0, 0, 1, 1, 0, 'h50, 'h99, 'h55AA55AA, 0);
        add(1, 0, 'h50, 'h99, 0, 0,        0, 0, 0, 'h50, 'h99, 0, 2'b10);
        // Misaligned store: no bus activity, first error stays.
        add(0, 1, 'h51, 'h77, 0, 0,        1, 0, 0, 'h50, 'h99, 0, 2'b10);
        add(0, 1, 'h51, 'h77, 0, 0,        0, 0, 0, 'h50, 'h99, 0, 2'b10);
        // Idle with a stray ack: ignored.
        add(0, 0, 0, 0, 1, 'hFFFFFFFF,     0, 0, 0, 'h50, 'h99, 0, 2'b10);
        add(0, 0, 0, 0, 0, 0,              0, 0, 0, 'h50, 'h99, 0, 2'b10);

        reset_i = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        repeat (3) next_cycle();
        check("reset rdata", rdata_o32, 32'h0);
        check("reset bus_addr", bus_addr_o32, 32'h0);
        check("reset bus_req", {31'h0, bus_req_o}, 32'h0);
        check("reset err_code", {30'h0, err_code_o2}, 32'h0);
        reset_i = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].ack, tbl[i].ardata);
            @(negedge clk_i);
            check($sformatf("v%0d stall", i), {31'h0, stall_o}, {31'h0, tbl[i].stall});
            check($sformatf("v%0d req", i), {31'h0, bus_req_o}, {31'h0, tbl[i].req});
            check($sformatf("v%0d we", i), {31'h0, bus_we_o}, {31'h0, tbl[i].we});
            check($sformatf("v%0d bus_addr", i), bus_addr_o32, tbl[i].baddr);
            check($sformatf("v%0d bus_wdata", i), bus_wdata_o32, tbl[i].bwdata);
            check($sformatf("v%0d rdata", i), rdata_o32, tbl[i].rdata);
            check($sformatf("v%0d err_code", i), {30'h0, err_code_o2}, {30'h0, tbl[i].ec});
            check($sformatf("v%0d err", i), {31'h0, err_o}, {31'h0, (tbl[i].ec != 2'b00)});
            next_cycle();
        end

        // Misaligned first, then a timeout: code must stay 01.
        reset_i = 1'b0;
        #2;
        reset_i = 1'b1;
        next_cycle();
        drive(1'b1, 1'b0, 32'h22, 32'h0, 1'b0, 32'h0);
        run_access(n_stall, n_req, done);
        check("misalign done", {31'h0, done}, 32'h1);
        check("misalign stall cycles", n_stall, 1);
        check("misalign req cycles", n_req, 0);
        check("misalign rdata", rdata_o32, 32'h0);
        check("misalign err_code", {30'h0, err_code_o2}, 32'h1);
        drive(1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 32'h0);
        run_access(n_stall, n_req, done);
        check("timeout done", {31'h0, done}, 32'h1);
        check("timeout req cycles", n_req, 4);
        check("timeout stall cycles", n_stall, 5);
        check("sticky err_code", {30'h0, err_code_o2}, 32'h1);
        check("sticky err", {31'h0, err_o}, 32'h1);

        // Reset asserted during BUSY drops the request at once.
        drive(1'b1, 1'b0, 32'h70, 32'h0, 1'b0, 32'h0);
        next_cycle();
        check("busy before reset req", {31'h0, bus_req_o}, 32'h1);
        #2;
        reset_i = 1'b0;
        #1;
        check("reset mid req", {31'h0, bus_req_o}, 32'h0);
        check("reset mid stall idle", {31'h0, stall_o}, 32'h1);
        check("reset mid bus_addr", bus_addr_o32, 32'h0);
        check("reset mid err_code", {30'h0, err_code_o2}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        #1;
        check("reset mid stall quiet", {31'h0, stall_o}, 32'h0);
        next_cycle();
        reset_i = 1'b1;
        next_cycle();
        drive(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 32'h0BADF00D);
        run_access(n_stall, n_req, done);
        check("post reset done", {31'h0, done}, 32'h1);
        check("post reset stall cycles", n_stall, 2);
        check("post reset req cycles", n_req, 1);
        check("post reset rdata", rdata_o32, 32'h0BADF00D);
        check("post reset err_code", {30'h0, err_code_o2}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Bridges the single-cycle datapath's load/store port to an external variable-latency data-memory bus. It sits directly downstream of the datapath:
- consumes the ALU result as address, register read data as store data, and the controller's memread/memwrite strobes;
- returns load data to the datapath's read-data input;
- raises a stall that freezes the PC register and register-file write until the bus transaction completes.

It also detects misaligned word accesses and bus timeouts, and reports them through a sticky error code.

## Interface
Parameters:
- TIMEOUT, 255, maximum cycles spent waiting for bus_ack_i before aborting (≥1)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  reset, asynchronous, active-low
- mem_read_i  in  1  load strobe from controller (mem_to_reg)
- mem_write_i  in  1  store strobe from controller
- addr_i32  in  32  byte address (datapath alu_out)
- wdata_i32  in  32  store data (datapath write_data)
- rdata_o32  out  32  load data to datapath read_data input
- stall_o  out  1  high: core must hold PC and suppress register write
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write enable
- bus_addr_o32  out  32  bus word address (byte address, [1:0]=00)
- bus_wdata_o32  out  32  bus write data
- bus_ack_i  in  1  bus completion, sampled on rising edge
- bus_rdata_i32  in  32  bus read data, valid when bus_ack_i high
- err_o  out  1  sticky error flag
- err_code_o2  out  2  sticky first error: 00 none, 01 misaligned, 10 timeout

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Access = mem_read_i | mem_write_i.
  - If both strobes are high, the access is a write and the read is ignored.
- IDLE:
  - stall_o = access (combinational).
  - On an edge with access and addr_i32[1:0]==00: capture addr, wdata and we into the bus registers; clear the timeout counter; go to BUSY.
  - On an edge with access and addr_i32[1:0]!=00: no bus transaction; rdata_q=0; if err_code is 00 set it to 01; go to DONE.
- BUSY:
  - bus_req_o=1 and stall_o=1.
  - bus_addr/we/wdata are held stable for the whole state.
  - On an edge with bus_ack_i=1: rdata_q ← bus_rdata_i32 for reads, unchanged for writes; go to DONE.
  - Else if counter==TIMEOUT-1: rdata_q=0; if err_code is 00 set it to 10; go to DONE.
  - Else counter+1.
  - If ack and timeout fall on the same edge, ack wins.
- DONE:
  - stall_o=0, so the core commits the instruction and the PC advances on this edge.
  - Unconditionally return to IDLE.
- rdata_o32 = rdata_q at all times, registered.
- bus_req_o is low in IDLE and DONE. The bus registers keep their last values outside BUSY.
- err_o = (err_code != 00). The error code is cleared only by reset; the first error wins.
- Counter width: $clog2(TIMEOUT+1); no wrap, because the state leaves BUSY at TIMEOUT-1.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - rdata_o32, bus_addr_o32 and bus_wdata_o32 all 0;
  - bus_we_o, bus_req_o and err_o all 0; err_code_o2 00.
  - stall_o follows the access inputs combinationally.
- Asserting reset_i low mid-transaction immediately drops bus_req_o, returns to IDLE and discards the transaction.
- Aligned access with ack after N cycles in BUSY (N≥1): the instruction occupies N+2 cycles (1 IDLE, N BUSY, 1 DONE). Minimum is 3 cycles when ack arrives in the first BUSY cycle.
- Misaligned access: 2 cycles (IDLE, DONE).
- Timeout: exactly TIMEOUT cycles in BUSY, TIMEOUT+2 cycles total.
- Back-to-back memory instructions: the next access is evaluated in the IDLE cycle that follows DONE. There is no overlap.
- Non-memory instructions: stall_o=0 and a 1-cycle throughput.
- The core must hold mem_*_i, addr and wdata stable while stall_o=1. The bridge samples them only at the IDLE→BUSY edge.

## Test plan
- Reset release, no access: stall_o=0, bus_req_o=0, rdata_o32=0, err_code_o2=00 for 10 cycles.
- Load to addr 0x0000_0010, ack on the 3rd BUSY cycle with rdata 0xCAFE_F00D:
  - bus_req_o high for 3 cycles with bus_addr_o32=0x10 and bus_we_o=0;
  - stall_o=1 for 4 cycles;
  - rdata_o32=0xCAFE_F00D in DONE.
- Store 0x1234_5678 to 0x20 with immediate ack: bus_we_o=1 and bus_wdata_o32=0x1234_5678 for one BUSY cycle; 3-cycle instruction; rdata_o32 unchanged.
- Load from 0x22 (misaligned): no bus_req_o; DONE after 1 stall cycle; rdata_o32=0; err_code_o2=01. A subsequent timeout leaves it at 01.
- TIMEOUT=4, ack never asserted:
  - bus_req_o high exactly 4 cycles;
  - err_code_o2=10, rdata_o32=0.
  - Same setup with ack on the 4th cycle: no error, data captured.
- reset_i low during BUSY: bus_req_o=0 immediately, state IDLE. A later aligned load completes normally.
